// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, the LSU FSM state type
// and small helpers that turn an access type into size, lane, byte enables and write data.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB  = 2'b00;
  localparam logic [1:0] F3_SH  = 2'b01;
  localparam logic [1:0] F3_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Reserved load encodings (011, 110, 111) fall through to a full word.
  function automatic acc_size_t load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_size = SZ_BYTE;
      F3_LH, F3_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_WORD;
    endcase
  endfunction

  function automatic acc_size_t store_size(input logic [1:0] f3);
    case (f3)
      F3_SB:   store_size = SZ_BYTE;
      F3_SH:   store_size = SZ_HALF;
      F3_SW:   store_size = SZ_WORD;
      default: store_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] natural_lane(input acc_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: natural_lane = lo;
      SZ_HALF: natural_lane = {lo[1], 1'b0};
      default: natural_lane = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] lo);
    is_misaligned = (natural_lane(sz, lo) != lo);
  endfunction

  function automatic logic [3:0] store_be(input acc_size_t sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: store_be = 4'b0001 << lane;
      SZ_HALF: store_be = 4'b0011 << lane;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the datum across the word lets memory pick it up with mem_be alone.
  function automatic logic [31:0] store_data(input acc_size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_rv32i_if.sv
// Data-memory request bus between the LSU (master) and data memory (slave).
// Handshake: master raises mem_req with mem_we/mem_addr/mem_be/mem_wdata and holds them
// stable until it samples mem_ack=1 on a rising edge; mem_rdata is valid in that ack cycle.
interface lsu_ctrl_rv32i_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Load-data alignment: picks the addressed byte/halfword lane of the read word
// and sign- or zero-extends it according to the load funct3.
module lsu_lane_align
  import rv32i_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lanes are always 0 or 2 here, so only lane[1] selects the half.
  assign w_byte = 8'(i_rdata >> {i_lane, 3'b000});
  assign w_half = 16'(i_rdata >> {i_lane[1], 4'b0000});

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl_rv32i.sv
// RV32I load/store controller: sequences one data-memory access per instruction (IDLE -> ACCESS -> DONE).
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses abort with ls_err instead of being aligned down.
module lsu_ctrl_rv32i
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ls_load,
  input  logic                    ls_store,
  input  logic [2:0]              ls_loadtype,
  input  logic [1:0]              ls_storetype,
  input  logic [31:0]             ls_addr,
  input  logic [31:0]             ls_wdata,
  lsu_ctrl_rv32i_if.master        mem,
  output logic                    ls_stall,
  output logic [31:0]             ls_rdata,
  output logic                    ls_done,
  output logic                    ls_err,
  output lsu_state_t              o_dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_next;

  logic        w_req;
  acc_size_t   w_size;
  logic [1:0]  w_lane;
  logic        w_trap;
  logic        w_timeout;
  logic [31:0] w_load_data;

  logic [29:0] r_addr_word;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_ltype;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  // A store wins when both decode strobes are present.
  assign w_req  = ls_load | ls_store;
  assign w_size = ls_store ? store_size(ls_storetype) : load_size(ls_loadtype);
  assign w_lane = natural_lane(w_size, ls_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_size, ls_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // r_cnt counts completed ACCESS cycles without ack; the last allowed cycle aborts.
  assign w_timeout = (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    ls_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ls_stall = w_req;
        if (w_req) begin
          w_next = w_trap ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ls_stall = 1'b1;
        if (mem.mem_ack || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_word <= 30'h0;
      r_we        <= 1'b0;
      r_be        <= 4'h0;
      r_wdata     <= 32'h0;
      r_ltype     <= 3'h0;
      r_lane      <= 2'h0;
      r_cnt       <= 8'h0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr_word <= ls_addr[31:2];
            r_we        <= ls_store;
            r_be        <= ls_store ? store_be(w_size, w_lane) : 4'hF;
            r_wdata     <= ls_store ? store_data(w_size, ls_wdata) : 32'h0;
            r_ltype     <= ls_loadtype;
            r_lane      <= w_lane;
            r_cnt       <= 8'h0;
            r_err       <= w_trap;
          end
        end
        ST_ACCESS: begin
          if (mem.mem_ack) begin
            r_err <= 1'b0;
            if (!r_we) begin
              r_rdata <= w_load_data;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  lsu_lane_align u_align (
    .i_rdata  (mem.mem_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_ltype),
    .o_data   (w_load_data)
  );

  assign mem.mem_req   = (r_state == ST_ACCESS);
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = {r_addr_word, 2'b00};
  assign mem.mem_be    = r_be;
  assign mem.mem_wdata = r_wdata;

  assign ls_done     = (r_state == ST_DONE);
  assign ls_err      = ls_done & r_err;
  assign ls_rdata    = r_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_ctrl_rv32i.sv
// Bench for lsu_ctrl_rv32i: directed load/store vectors, a transaction-level model
// checked every cycle, and literal expectations for the hand-worked cases.
module tb_lsu_ctrl_rv32i;
  import rv32i_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_load, ls_store;
  logic [2:0]  ls_loadtype;
  logic [1:0]  ls_storetype;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_stall, ls_done, ls_err;
  logic [31:0] ls_rdata;
  lsu_state_t  dbg_state;

  lsu_ctrl_rv32i_if mem_bus ();

  lsu_ctrl_rv32i #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ls_load      (ls_load),
    .ls_store     (ls_store),
    .ls_loadtype  (ls_loadtype),
    .ls_storetype (ls_storetype),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .mem          (mem_bus),
    .ls_stall     (ls_stall),
    .ls_rdata     (ls_rdata),
    .ls_done      (ls_done),
    .ls_err       (ls_err),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int acc_bytes(input logic st, input logic [2:0] lt, input logic [1:0] sty);
    if (st) return (sty == 2'b00) ? 1 : (sty == 2'b01) ? 2 : 4;
    case (lt)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [31:0] word, input int lane,
                                              input int bytes, input logic [2:0] lt);
    logic [31:0] v;
    logic [31:0] mask;
    if (bytes == 4) return word;
    mask = (bytes == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (word >> (8 * lane)) & mask;
    if (!lt[2] && v[8 * bytes - 1]) v = v | ~mask;
    return v;
  endfunction

  bit          m_known = 0;
  bit          m_pend  = 0;
  bit          m_done  = 0;
  bit          m_err   = 0;
  bit          m_we    = 0;
  int          m_waited, m_lane, m_bytes;
  logic [2:0]  m_lt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  always @(posedge clk) begin : model
    int          bytes;
    int          off;
    logic [31:0] al;
    if (rst) begin
      m_known = 1;
      m_pend  = 0;
      m_done  = 0;
      m_err   = 0;
      m_rdata = 32'h0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_pend) begin
      m_waited++;
      if (mem_bus.mem_ack) begin
        m_pend = 0;
        m_done = 1;
        m_err  = 0;
        if (!m_we) m_rdata = load_result(mem_bus.mem_rdata, m_lane, m_bytes, m_lt);
      end else if (m_waited >= TO) begin
        m_pend  = 0;
        m_done  = 1;
        m_err   = 1;
        m_rdata = 32'h0;
      end
    end else if (ls_load || ls_store) begin
      bytes   = acc_bytes(ls_store, ls_loadtype, ls_storetype);
      off     = int'(ls_addr[1:0]) % bytes;
      al      = ls_addr - 32'(off);
      m_addr  = {al[31:2], 2'b00};
      m_lane  = int'(al[1:0]);
      m_bytes = bytes;
      m_we    = ls_store;
      m_lt    = ls_loadtype;
      m_be    = ls_store ? 4'(((1 << bytes) - 1) << m_lane) : 4'hF;
      m_wdata = (bytes == 1) ? {24'h0, ls_wdata[7:0]} * 32'h0101_0101 :
                (bytes == 2) ? {16'h0, ls_wdata[15:0]} * 32'h0001_0001 : ls_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
      if (off != 0) begin
        m_done = 1;
        m_err  = 1;
      end else begin
        m_pend   = 1;
        m_waited = 0;
      end
`else
      m_pend   = 1;
      m_waited = 0;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_known) begin
      chk("mem_req", {31'h0, mem_bus.mem_req}, {31'h0, m_pend});
      if (m_pend) begin
        chk("mem_we",   {31'h0, mem_bus.mem_we}, {31'h0, m_we});
        chk("mem_addr", mem_bus.mem_addr, m_addr);
        chk("mem_be",   {28'h0, mem_bus.mem_be}, {28'h0, m_be});
        if (m_we) chk("mem_wdata", mem_bus.mem_wdata, m_wdata);
      end
      chk("ls_done",  {31'h0, ls_done}, {31'h0, m_done});
      chk("ls_err",   {31'h0, ls_err}, {31'h0, (m_done && m_err)});
      chk("ls_rdata", ls_rdata, m_rdata);
      chk("ls_stall", {31'h0, ls_stall},
          {31'h0, (m_pend || (!m_done && (ls_load || ls_store)))});
    end
  end

  // ---------------- driver ----------------
  int          t_lat, t_req;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_be;
  logic        t_we, t_err;

  // dly: ACCESS cycles before ack is driven (0 = ack in first ACCESS cycle, <0 = never).
  task automatic run_req(input logic ld, input logic st, input logic [2:0] lt,
                         input logic [1:0] sty, input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input logic [31:0] rd);
    int budget;
    ls_load = ld; ls_store = st; ls_loadtype = lt; ls_storetype = sty;
    ls_addr = a;  ls_wdata = wd;
    t_req = 0; t_lat = 0;
    tick();
    t_lat = 1;
    ls_load = 1'b0; ls_store = 1'b0;
    budget = 0;
    while (!ls_done && budget < 20) begin
      if (mem_bus.mem_req) begin
        t_req++;
        t_addr = mem_bus.mem_addr; t_be = mem_bus.mem_be;
        t_we = mem_bus.mem_we;     t_wdata = mem_bus.mem_wdata;
      end
      if (dly >= 0 && budget == dly) begin
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rd;
      end
      tick();
      mem_bus.mem_ack = 1'b0;
      t_lat++;
      budget++;
    end
    chk("done_seen", {31'h0, ls_done}, 32'h1);
    t_err   = ls_err;
    t_rdata = ls_rdata;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ls_load = 1'b0; ls_store = 1'b0; ls_loadtype = 3'h0; ls_storetype = 2'h0;
    ls_addr = 32'h0; ls_wdata = 32'h0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_req",   {31'h0, mem_bus.mem_req}, 32'h0);
    chk("rst_we",    {31'h0, mem_bus.mem_we}, 32'h0);
    chk("rst_be",    {28'h0, mem_bus.mem_be}, 32'h0);
    chk("rst_addr",  mem_bus.mem_addr, 32'h0);
    chk("rst_wdata", mem_bus.mem_wdata, 32'h0);
    chk("rst_rdata", ls_rdata, 32'h0);
    chk("rst_done",  {31'h0, ls_done}, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // SW 0x100, ack in first ACCESS cycle
    run_req(1'b0, 1'b1, F3_LW, F3_SW, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);
    chk("sw_addr", t_addr, 32'h100);
    chk("sw_be",   {28'h0, t_be}, 32'hF);
    chk("sw_we",   {31'h0, t_we}, 32'h1);
    chk("sw_data", t_wdata, 32'hDEAD_BEEF);
    chk("sw_lat",  t_lat, 2);
    chk("sw_err",  {31'h0, t_err}, 32'h0);

    run_req(1'b0, 1'b1, F3_LW, F3_SB, 32'h103, 32'h0000_00A5, 1, 32'h0);
    chk("sb_be",   {28'h0, t_be}, 32'h8);
    chk("sb_data", t_wdata, 32'hA5A5_A5A5);
    chk("sb_lat",  t_lat, 3);

    run_req(1'b1, 1'b0, F3_LB,  F3_SB, 32'h102, 32'h0, 0, 32'h12F0_3456);
    chk("lb_rdata", t_rdata, 32'hFFFF_FFF0);
    run_req(1'b1, 1'b0, F3_LBU, F3_SB, 32'h102, 32'h0, 0, 32'h12F0_3456);
    chk("lbu_rdata", t_rdata, 32'h0000_00F0);
    run_req(1'b1, 1'b0, F3_LHU, F3_SB, 32'h102, 32'h0, 0, 32'h12F0_3456);
    chk("lhu_rdata", t_rdata, 32'h0000_12F0);
    run_req(1'b1, 1'b0, F3_LH,  F3_SB, 32'h102, 32'h0, 2, 32'h8000_1234);
    chk("lh_rdata", t_rdata, 32'hFFFF_8000);

    run_req(1'b0, 1'b1, F3_LW, F3_SH, 32'h106, 32'h1234_BEEF, 2, 32'h0);
    chk("sh_be",    {28'h0, t_be}, 32'hC);
    chk("sh_data",  t_wdata, 32'hBEEF_BEEF);
    chk("sh_addr",  t_addr, 32'h104);
    chk("sh_keeprd", t_rdata, 32'hFFFF_8000);

    run_req(1'b1, 1'b0, 3'b011, F3_SB, 32'h104, 32'h0, 0, 32'hCAFE_F00D);
    chk("rsv_rdata", t_rdata, 32'hCAFE_F00D);
    chk("rsv_be",    {28'h0, t_be}, 32'hF);

    run_req(1'b1, 1'b0, F3_LW, F3_SB, 32'h101, 32'h0, 0, 32'h5566_7788);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req",   t_req, 0);
    chk("mis_err",   {31'h0, t_err}, 32'h1);
    chk("mis_rdata", t_rdata, 32'hCAFE_F00D);
`else
    chk("mis_addr",  t_addr, 32'h100);
    chk("mis_err",   {31'h0, t_err}, 32'h0);
    chk("mis_rdata", t_rdata, 32'h5566_7788);
`endif

    run_req(1'b1, 1'b0, F3_LHU, F3_SB, 32'h103, 32'h0, 0, 32'hBEEF_0000);

    run_req(1'b1, 1'b0, F3_LW, F3_SB, 32'h200, 32'h0, -1, 32'h0);
    chk("to_reqcyc", t_req, 4);
    chk("to_err",    {31'h0, t_err}, 32'h1);
    chk("to_rdata",  t_rdata, 32'h0);
    chk("to_lat",    t_lat, 5);

    run_req(1'b1, 1'b1, F3_LW, F3_SW, 32'h108, 32'h1111_1111, 0, 32'h9999_9999);
    chk("both_we",   {31'h0, t_we}, 32'h1);
    chk("both_rd",   t_rdata, 32'h0);

    run_req(1'b1, 1'b0, F3_LB, F3_SB, 32'h001, 32'h0, 1, 32'h0000_7F00);
    chk("lb_pos", t_rdata, 32'h0000_007F);

    // request held during DONE and an ack while idle are both ignored
    ls_load = 1'b1; ls_loadtype = F3_LW; ls_addr = 32'h40;
    tick();
    ls_load = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("dn_done", {31'h0, ls_done}, 32'h1);
    ls_load = 1'b1; ls_addr = 32'h80;
    #1;
    chk("dn_stall", {31'h0, ls_stall}, 32'h0);
    tick();
    ls_load = 1'b0;
    chk("dn_ignore", {31'h0, mem_bus.mem_req}, 32'h0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("idle_ack", {31'h0, ls_done}, 32'h0);
    chk("dn_rdata", ls_rdata, 32'h0BAD_F00D);
    tick();

    // reset during the second ACCESS cycle, then a late ack
    ls_load = 1'b1; ls_loadtype = F3_LW; ls_addr = 32'h300;
    tick();
    ls_load = 1'b0;
    tick();
    chk("ra_req", {31'h0, mem_bus.mem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_req0",  {31'h0, mem_bus.mem_req}, 32'h0);
    chk("ra_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ra_done",  {31'h0, ls_done}, 32'h0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("ra_late",  {31'h0, ls_done}, 32'h0);
    chk("ra_rdata", ls_rdata, 32'h0);
    tick();

    run_req(1'b0, 1'b1, F3_LW, F3_SB, 32'h000, 32'h0000_007E, 0, 32'h0);
    chk("rec_be",   {28'h0, t_be}, 32'h1);
    chk("rec_data", t_wdata, 32'h7E7E_7E7E);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
